fp_scaleb_pipe: RTL and testbench

Parametrised, pipelined floating-point scaleb: o = a × 2^b, where a is an IEEE-style binary float of configurable exponent and fraction width and b is a signed integer.
Successor to the fixed-width scaleb unit, and adds:
- a valid pipeline
- asynchronous reset
- denormal input normalisation
- gradual underflow with round-to-nearest-even
- quiet-NaN propagation
Sits in the FPU execute cluster alongside the other fixed-latency ops and shares their ce-stall convention.

---
 rtl/fp_scaleb_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fp_scaleb_pipe.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_scaleb_pipe.sv
// Three-stage floating-point scaleb: o = a * 2^b with denormal normalisation, RNE gradual underflow and qNaN propagation.
// Optional IEEE flags (ovf_o/unf_o/inx_o) are built only when FP_SCALEB_FLAGS_EN is defined.
module fp_scaleb_pipe #(
  parameter int EWID = 8,
  parameter int FMSB = 22,
  parameter int BWID = 16,
  localparam int FPWID = 1 + EWID + FMSB + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             valid_i,
  input  logic [FPWID-1:0] a,
  input  logic [BWID-1:0]  b,
  output logic             valid_o,
  output logic [FPWID-1:0] o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             inx_o
);

  localparam int MW  = FMSB + 2;
  localparam int SW  = ((EWID > BWID) ? EWID : BWID) + 2;
  localparam int LZW = $clog2(FMSB + 2);

  localparam logic signed [SW-1:0] S_ZERO = {SW{1'b0}};
  localparam logic signed [SW-1:0] S_ONE  = SW'(1);
  localparam logic signed [SW-1:0] S_OVF  = SW'((2 ** EWID) - 1);
  localparam logic        [SW-1:0] SH_CAP = SW'(MW + 1);

  typedef enum logic [1:0] {
    CLS_FIN  = 2'd0,
    CLS_PASS = 2'd1,
    CLS_NAN  = 2'd2
  } cls_e;

  function automatic logic [LZW-1:0] lzc(input logic [FMSB:0] f);
    logic [LZW-1:0] n;
    n = LZW'(FMSB + 1);
    for (int i = 0; i <= FMSB; i++) begin
      if (f[i]) n = LZW'(FMSB - i);
    end
    return n;
  endfunction

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [FPWID-1:0]     a1_q, a1_d, a2_q, a2_d, o3_q, o3_d;
  cls_e                 cls1_q, cls1_d, cls2_q, cls2_d;
  logic [MW-1:0]        m1_q, m1_d, m2_q, m2_d;
  logic signed [SW-1:0] e1_q, e1_d, b1_q, b1_d, s2_q, s2_d;
`ifdef FP_SCALEB_FLAGS_EN
  logic                 ovf3_q, ovf3_d, unf3_q, unf3_d, inx3_q, inx3_d;
`endif

  logic [EWID-1:0]   exp_s;
  logic [FMSB:0]     frac_s;
  logic [LZW-1:0]    lz_s;
  logic [SW-1:0]     sh_s;
  logic [2*MW-1:0]   wide_s;
  logic [MW-1:0]     kept_s, rnd_s;
  logic              guard_s, sticky_s, sign_s;

  assign exp_s  = a[FPWID-2 -: EWID];
  assign frac_s = a[FMSB:0];

  // Stage 1: classify a, normalise denormals (hidden bit forced into m[MW-1]), sign-extend b
  always_comb begin
    lz_s   = lzc(frac_s);
    cls1_d = CLS_FIN;
    m1_d   = {1'b1, frac_s};
    e1_d   = {{(SW-EWID){1'b0}}, exp_s};
    if (exp_s == {EWID{1'b1}}) begin
      if (frac_s != {(FMSB+1){1'b0}}) cls1_d = CLS_NAN;
      else                            cls1_d = CLS_PASS;
    end else if (exp_s == {EWID{1'b0}}) begin
      if (frac_s == {(FMSB+1){1'b0}}) begin
        cls1_d = CLS_PASS;
      end else begin
        m1_d = {1'b0, frac_s} << ({1'b0, lz_s} + {{LZW{1'b0}}, 1'b1});
        e1_d = S_ZERO - SW'(lz_s);
      end
    end else begin
      cls1_d = CLS_FIN;
    end
    b1_d = {{(SW-BWID){b[BWID-1]}}, b};
    a1_d = a;
    v1_d = valid_i;
  end

  // Stage 2: exponent sum; SW leaves headroom so extreme b never wraps
  always_comb begin
    s2_d   = e1_q + b1_q;
    m2_d   = m1_q;
    cls2_d = cls1_q;
    a2_d   = a1_q;
    v2_d   = v1_q;
  end

  // Stage 3: assemble special / overflow / normal / gradual-underflow result
  always_comb begin
    sign_s   = a2_q[FPWID-1];
    sh_s     = S_ONE - s2_q;
    wide_s   = {m2_q, {MW{1'b0}}} >> sh_s;
    kept_s   = wide_s[2*MW-1:MW];
    guard_s  = wide_s[MW-1];
    sticky_s = |wide_s[MW-2:0];
    if (sh_s >= SH_CAP) begin
      kept_s   = {MW{1'b0}};
      guard_s  = 1'b0;
      sticky_s = |m2_q;
    end else begin
      kept_s   = wide_s[2*MW-1:MW];
    end
    rnd_s = kept_s + {{(MW-1){1'b0}}, guard_s & (sticky_s | kept_s[0])};
    v3_d  = v2_q;
`ifdef FP_SCALEB_FLAGS_EN
    ovf3_d = 1'b0;
    unf3_d = 1'b0;
    inx3_d = 1'b0;
`endif
    case (cls2_q)
      CLS_NAN:  o3_d = a2_q | (FPWID'(1) << FMSB);
      CLS_PASS: o3_d = a2_q;
      CLS_FIN: begin
        if (s2_q >= S_OVF) begin
          o3_d = {sign_s, {EWID{1'b1}}, {(FMSB+1){1'b0}}};
`ifdef FP_SCALEB_FLAGS_EN
          ovf3_d = 1'b1;
`endif
        end else if (s2_q >= S_ONE) begin
          o3_d = {sign_s, s2_q[EWID-1:0], m2_q[FMSB:0]};
        end else begin
          // A rounding carry lands in the exp LSB, giving the smallest normal
          o3_d = {sign_s, {(EWID-1){1'b0}}, rnd_s[FMSB+1], rnd_s[FMSB:0]};
`ifdef FP_SCALEB_FLAGS_EN
          inx3_d = guard_s | sticky_s;
          unf3_d = guard_s | sticky_s;
`endif
        end
      end
      default:  o3_d = a2_q;
    endcase
  end

  // Pipeline registers: async clear, hold on ce low, data loads regardless of valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= {FPWID{1'b0}};
      a2_q   <= {FPWID{1'b0}};
      o3_q   <= {FPWID{1'b0}};
      cls1_q <= CLS_FIN;
      cls2_q <= CLS_FIN;
      m1_q   <= {MW{1'b0}};
      m2_q   <= {MW{1'b0}};
      e1_q   <= S_ZERO;
      b1_q   <= S_ZERO;
      s2_q   <= S_ZERO;
`ifdef FP_SCALEB_FLAGS_EN
      ovf3_q <= 1'b0;
      unf3_q <= 1'b0;
      inx3_q <= 1'b0;
`endif
    end else if (ce) begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      o3_q   <= o3_d;
      cls1_q <= cls1_d;
      cls2_q <= cls2_d;
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      e1_q   <= e1_d;
      b1_q   <= b1_d;
      s2_q   <= s2_d;
`ifdef FP_SCALEB_FLAGS_EN
      ovf3_q <= ovf3_d;
      unf3_q <= unf3_d;
      inx3_q <= inx3_d;
`endif
    end
  end

  assign valid_o = v3_q;
  assign o       = o3_q;
`ifdef FP_SCALEB_FLAGS_EN
  assign ovf_o = ovf3_q;
  assign unf_o = unf3_q;
  assign inx_o = inx3_q;
`else
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
  assign inx_o = 1'b0;
`endif

endmodule

// File: tb/tb_fp_scaleb_pipe.sv
// Randomised + directed bench for fp_scaleb_pipe (single precision); integer-arithmetic reference model and due-cycle scoreboard.
module tb_fp_scaleb_pipe;

  logic        clk = 1'b0;
  logic        rst_n, ce, valid_i;
  logic [31:0] a;
  logic [15:0] b;
  logic        valid_o;
  logic [31:0] o;
  logic        ovf_o, unf_o, inx_o;

  always #5 clk = ~clk;

  fp_scaleb_pipe dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_i(valid_i), .a(a), .b(b),
    .valid_o(valid_o), .o(o), .ovf_o(ovf_o), .unf_o(unf_o), .inx_o(inx_o)
  );

  typedef struct {
    logic [34:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ce_cnt  = 0;
  logic        last_v;
  logic [31:0] last_o;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // value = mant * 2^e, re-encoded from scratch; returns {ovf, unf, inx, o}
  function automatic logic [34:0] ref_model(input logic [31:0] aa, input logic [15:0] bb);
    int     bs, ex, e, p, bexp, k;
    longint mant, q, rem, half;
    logic   s, inx;
    bs = int'($signed(bb));
    s  = aa[31];
    ex = int'(aa[30:23]);
    if (ex == 255) begin
      if (aa[22:0] != 23'd0) return {3'b000, aa | 32'h0040_0000};
      else                   return {3'b000, aa};
    end
    if (ex == 0 && aa[22:0] == 23'd0) return {3'b000, aa};
    mant = (ex == 0) ? longint'(aa[22:0]) : longint'(aa[22:0]) + 64'd8388608;
    e    = ((ex == 0) ? 1 : ex) - 150 + bs;
    p    = 0;
    for (int i = 0; i < 24; i++) if (mant[i]) p = i;
    bexp = p + e + 127;
    if (bexp >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (bexp >= 1)   return {3'b000, s, 8'(bexp), 23'(mant << (23 - p))};
    k = -(e + 149);
    rem = 0;
    if (k <= 0) begin
      q = mant << (-k);
    end else if (k > 60) begin
      q   = 0;
      rem = mant;
    end else begin
      q    = mant >> k;
      rem  = mant - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    inx = (rem != 0);
    return {1'b0, inx, inx, s, 31'(q)};
  endfunction

  task automatic step(input logic c, input logic v, input logic [31:0] aa, input logic [15:0] bb);
    exp_t x;
    ce = c; valid_i = v; a = aa; b = bb;
    @(posedge clk);
    if (c) begin
      ce_cnt++;
      if (v) begin
        x.res = ref_model(aa, bb);
        x.due = ce_cnt + 2;
        sb.push_back(x);
      end
    end
    @(negedge clk);
    if (!c) begin
      check_eq("hold_valid", valid_o, last_v);
      check_eq("hold_o", o, last_o);
    end else if (sb.size() > 0 && sb[0].due == ce_cnt) begin
      check_eq("valid_o", valid_o, 1'b1);
      check_eq("o", o, sb[0].res[31:0]);
`ifdef FP_SCALEB_FLAGS_EN
      check_eq("flags", {ovf_o, unf_o, inx_o}, sb[0].res[34:32]);
`else
      check_eq("flags", {ovf_o, unf_o, inx_o}, 3'b000);
`endif
      void'(sb.pop_front());
    end else begin
      check_eq("idle_valid", valid_o, 1'b0);
    end
    last_v = valid_o;
    last_o = o;
  endtask

  logic [31:0] da[12] = '{32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h3F800000,
                          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000001,
                          32'h80000001, 32'h7FA00000, 32'hFF800000, 32'h80000000};
  logic [15:0] db[12] = '{16'd3, 16'd2, 16'h7FFF, 16'hFF81, 16'hFF6B, 16'hFF6A,
                          16'h8000, 16'd149, 16'd0, 16'd5, 16'hFED4, 16'd100};
  logic        cepat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    logic [7:0]  rexp;
    rst_n = 1'b0; ce = 1'b0; valid_i = 1'b0; a = 32'd0; b = 16'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_o", o, 32'd0);
    check_eq("rst_flags", {ovf_o, unf_o, inx_o}, 3'b000);
    rst_n  = 1'b1;
    last_v = valid_o;
    last_o = o;

    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, da[i], db[i]);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 16'd0);

    for (int i = 0; i < 5; i++) step(cepat[i], 1'b1, $urandom, 16'($urandom_range(0, 40)));
    for (int i = 0; i < 5; i++) step(i % 2 == 0, 1'b0, 32'd0, 16'd0);

    for (int i = 0; i < 400; i++) begin
      rexp = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       rexp = 8'h00;
        1:       rexp = 8'hFF;
        2:       rexp = 8'($urandom_range(0, 4));
        default: rexp = 8'($urandom);
      endcase
      ra = {1'($urandom), rexp, 23'($urandom)};
      if ($urandom_range(0, 9) == 0) ra[22:0] = 23'd0;
      if ($urandom_range(0, 1) == 0) rb = 16'(int'($urandom_range(0, 600)) - 300);
      else                           rb = 16'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, ra, rb);
    end
    for (int i = 0; i < 10; i++) if (sb.size() > 0) step(1'b1, 1'b0, 32'd0, 16'd0);
    check_eq("drain", sb.size(), 0);

    step(1'b1, 1'b1, 32'h3F800000, 16'd1);
    step(1'b1, 1'b1, 32'h40000000, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", valid_o, 1'b0);
    check_eq("midrst_o", o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    last_v = valid_o;
    last_o = o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
